// File: rtl/xalu_issue_ctrl.sv
// XALU issue controller: registers IU ops toward the XALU, tracks per-thread
// outstanding divides with replay forwarding, and meters divider queue credits.

package xalu_pkg;

   localparam int unsigned NTHREAD      = 32;
   localparam int unsigned NTHREADIDMSB = 4;
   localparam int unsigned TIDW         = NTHREADIDMSB + 1;

   typedef struct packed {
      logic clk;
   } iu_clk_type;

   typedef logic [2:0] mul_ctrl_type;

   localparam mul_ctrl_type c_UMUL   = 3'd0;
   localparam mul_ctrl_type c_SMUL   = 3'd1;
   localparam mul_ctrl_type c_UDIV   = 3'd2;
   localparam mul_ctrl_type c_SDIV   = 3'd3;
   localparam mul_ctrl_type c_SLL    = 3'd4;
   localparam mul_ctrl_type c_SRL    = 3'd5;
   localparam mul_ctrl_type c_SRA    = 3'd6;
   localparam mul_ctrl_type c_MULSCC = 3'd7;

   typedef struct packed {
      logic [TIDW-1:0] tid;
      mul_ctrl_type    mode;
      logic [31:0]     op1;
      logic [31:0]     op2;
   } xalu_ififo_type;

   typedef struct packed {
      logic           valid;
      logic           replay;
      logic           op2zero;
      xalu_ififo_type ififo_data;
      logic [31:0]    y;
   } xalu_dsp_in_type;

endpackage

module xalu_issue_ctrl #(
   parameter int unsigned NTHREAD    = xalu_pkg::NTHREAD,
   parameter int unsigned DIVQ_DEPTH = 16
) (
   input  xalu_pkg::iu_clk_type      gclk,
   input  logic                      rst,
   input  logic                      iu_valid,
   input  logic [((NTHREAD > 1) ? $clog2(NTHREAD) : 1)-1:0] iu_tid,
   input  xalu_pkg::mul_ctrl_type    iu_mode,
   input  logic [31:0]               iu_op1,
   input  logic [31:0]               iu_op2,
   input  logic [31:0]               iu_y,
   input  logic                      new_replay,
   input  logic                      div_done,
   output xalu_pkg::xalu_dsp_in_type xalu_in,
   output logic                      credit_stall,
   output logic [NTHREAD-1:0]        pend_vec,
   output logic                      credit_err
);

   localparam int unsigned TIDW  = (NTHREAD > 1) ? $clog2(NTHREAD) : 1;
   localparam int unsigned PTIDW = xalu_pkg::TIDW;
   localparam int unsigned CW    = $clog2(DIVQ_DEPTH + 1);

   logic clk;
   assign clk = gclk.clk;

   xalu_pkg::xalu_dsp_in_type xalu_q, xalu_d;
   logic [NTHREAD-1:0]        pend_q, pend_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      stall_q, stall_d;
   logic                      err_q, err_d;
   logic                      sh_valid_q, sh_valid_d;
   logic                      sh_div_q, sh_div_d;
   logic [TIDW-1:0]           sh_tid_q, sh_tid_d;

   logic is_div_c;
   logic op2zero_c;
   logic fwd_c;
   logic replay_c;
   logic new_div_c;
   logic drop_c;
   logic accept_c;
   logic underflow_c;
   logic release_c;

   // Issue decision, pend tracking and credit accounting for the op at the IU boundary
   always_comb begin
      xalu_d      = '0;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      sh_valid_d  = 1'b0;
      sh_div_d    = 1'b0;
      sh_tid_d    = iu_tid;

      is_div_c    = (iu_mode == xalu_pkg::c_UDIV) || (iu_mode == xalu_pkg::c_SDIV);
      op2zero_c   = (iu_op2 == 32'd0);
      // The stage-1 op's replay verdict lands this cycle; the pend bit is still stale
      fwd_c       = sh_valid_q & sh_div_q & (sh_tid_q == iu_tid);
      replay_c    = fwd_c ? new_replay : pend_q[iu_tid];
      new_div_c   = iu_valid & is_div_c & ~replay_c & ~op2zero_c;
      drop_c      = new_div_c & stall_q;
      accept_c    = new_div_c & ~stall_q;
      underflow_c = div_done & (cnt_q == CW'(0));
      release_c   = div_done & ~underflow_c;

      xalu_d.valid           = iu_valid & ~drop_c;
      xalu_d.replay          = replay_c;
      xalu_d.op2zero         = op2zero_c;
      xalu_d.ififo_data.tid  = PTIDW'(iu_tid);
      xalu_d.ififo_data.mode = iu_mode;
      xalu_d.ififo_data.op1  = iu_op1;
      xalu_d.ififo_data.op2  = iu_op2;
      xalu_d.y               = iu_y;

      if (sh_valid_q && sh_div_q) begin
         pend_d[sh_tid_q] = new_replay;
      end

      case ({accept_c, release_c})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase

      err_d      = err_q | drop_c | underflow_c;
      stall_d    = (cnt_d == CW'(DIVQ_DEPTH));

      sh_valid_d = xalu_d.valid;
      sh_div_d   = is_div_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xalu_q     <= '0;
         pend_q     <= '0;
         cnt_q      <= '0;
         stall_q    <= 1'b0;
         err_q      <= 1'b0;
         sh_valid_q <= 1'b0;
         sh_div_q   <= 1'b0;
         sh_tid_q   <= '0;
      end else begin
         xalu_q     <= xalu_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         stall_q    <= stall_d;
         err_q      <= err_d;
         sh_valid_q <= sh_valid_d;
         sh_div_q   <= sh_div_d;
         sh_tid_q   <= sh_tid_d;
      end
   end

   assign xalu_in      = xalu_q;
   assign credit_stall = stall_q;
   assign pend_vec     = pend_q;
   assign credit_err   = err_q;

endmodule
